load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle data-memory access stage downstream of the ALU: consumes the ALU result (address),
//  read_data2 (store data), MemRead/MemWrite and funct3. Drives a valid/ready memory bus and
//  returns sign/zero-extended load data to the write-back mux. Asserts stall to freeze PC while
//  an access is in flight. Flags misaligned/illegal accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles in REQ without bus_ready before abort (>=2)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   synchronous, active-high
//  MemRead      in   1   load instruction present
//  MemWrite     in   1   store instruction present (wins if both high)
//  fun3         in   3   instruction[14:12]: access size/signedness
//  address      in   32  byte address from ALU
//  Write_data   in   32  store data (rs2)
//  MemData_out  out  32  registered, extended load result
//  stall        out  1   hold PC/pipeline this cycle
//  fault        out  1   one-cycle pulse: misaligned, illegal fun3 or timeout
//  bus_req      out  1   request valid
//  bus_we       out  1   1=write, 0=read
//  bus_addr     out  32  word-aligned address ({address[31:2],2'b00})
//  bus_wdata    out  32  lane-replicated store data
//  bus_be       out  4   byte enables (bit i = byte lane i)
//  bus_ready    in   1   slave accepts/completes; transfer on bus_req & bus_ready
//  bus_rdata    in   32  read data, valid when bus_ready high on a read
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (MemData_out, stall, fault, bus_*); timeout counter 0.
//  FSM IDLE -> REQ -> DONE -> IDLE; IDLE -> ERR -> IDLE; REQ -> ERR on timeout.
//  - IDLE: access = MemRead|MemWrite. No access: stall=0. Access: stall=1 (combinational, same
//    cycle). Legal+aligned -> latch addr/we/wdata/be/fun3, go REQ. Misaligned or illegal -> ERR.
//  - Legal fun3: loads 000 LB,001 LH,010 LW,100 LBU,101 LHU; stores 000 SB,001 SH,010 SW.
//    Others illegal. Misaligned: half with addr[0]=1; word with addr[1:0]!=0. Bytes never misaligned.
//  - REQ: bus_req=1, stall=1; addr/we/wdata/be held stable until handshake. On bus_req&bus_ready:
//    load captures lane of bus_rdata, extends, registers to MemData_out; go DONE. Counter +1 per
//    REQ cycle without ready; at TIMEOUT_CYCLES-1 with no ready -> drop bus_req, go ERR.
//  - DONE: stall=0, bus_req=0; PC advances this edge. Access inputs ignored (same instruction
//    still presented); unconditional -> IDLE.
//  - ERR: fault=1, stall=0, bus_req=0; MemData_out unchanged; -> IDLE.
//  Store lanes: SB wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0]; SH wdata={2{d[15:0]}},
//    be=addr[1]?4'b1100:4'b0011; SW wdata=d, be=4'b1111. Loads drive be per same rule, we=0.
//  Load extract: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16]; LB/LH sign-extend,
//    LBU/LHU zero-extend, LW passthrough. Stores never modify MemData_out.
//  Latency: zero-wait slave = 3 cycles/access (IDLE,REQ,DONE), stall high 2 cycles. Each wait
//    cycle adds one. Fault path = 2 cycles, stall high 1.
//  Reset mid-access: next edge forces IDLE, bus_req=0, stall=0; abandoned request not retried;
//    slave must tolerate req drop.
//  bus_ready while bus_req=0 is ignored.
// TESTING
//  1 SW addr=0x100 d=0xDEADBEEF, ready=1 -> be=4'hF, wdata=0xDEADBEEF, stall 2 cyc, fault=0.
//  2 SB addr=0x103 d=0x000000A5 -> bus_addr=0x100, be=4'b1000, wdata=0xA5A5A5A5.
//  3 rdata=0x12F03456: LB 0x102 -> 0xFFFFFFF0; LBU 0x102 -> 0x000000F0; LH 0x102 -> 0x000012F0.
//  4 LW addr=0x102 -> no bus_req, fault 1 cyc, MemData_out keeps prior value; fun3=011 same.
//  5 LW, bus_ready=0 held -> bus_req high 64 cyc then 0, fault pulse, stall released.
//  6 reset asserted in REQ with 3 wait cycles -> next cycle bus_req=0, stall=0, MemData_out=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: steers store lanes onto a valid/ready data bus, extends load
// data for write-back, holds the pipeline while busy and pulses fault on bad or timed-out accesses.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  fun3,
   input  logic [31:0] address,
   input  logic [31:0] Write_data,
   output logic [31:0] MemData_out,
   output logic        stall,
   output logic        fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [1:0]        lo_r;
   logic [2:0]        f3_r;
   logic [31:0]       mem_data_r;
   logic              fault_r;
   logic              bus_req_r;
   logic              bus_we_r;
   logic [31:0]       bus_addr_r;
   logic [31:0]       bus_wdata_r;
   logic [3:0]        bus_be_r;

   logic              access_s;
   logic              legal_s;
   logic              misaligned_s;
   logic [3:0]        be_s;
   logic [31:0]       wdata_s;

   // Picks the addressed lane out of the read word and sign/zero-extends it.
   function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                               input logic [1:0]  lo,
                                               input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lo)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         2'd3:    b = rdata[31:24];
         default: b = rdata[7:0];
      endcase
      h = lo[1] ? rdata[31:16] : rdata[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b010:  r = rdata;
         3'b100:  r = {24'h000000, b};
         3'b101:  r = {16'h0000, h};
         default: r = rdata;
      endcase
      return r;
   endfunction

   // Decode of the presented access: legality, alignment and lane steering.
   always_comb begin
      access_s     = MemRead | MemWrite;
      misaligned_s = 1'b0;
      be_s         = 4'b0000;
      wdata_s      = Write_data;
      case (fun3[1:0])
         2'b00: begin
            be_s    = 4'b0001 << address[1:0];
            wdata_s = {4{Write_data[7:0]}};
         end
         2'b01: begin
            be_s         = address[1] ? 4'b1100 : 4'b0011;
            wdata_s      = {2{Write_data[15:0]}};
            misaligned_s = address[0];
         end
         2'b10: begin
            be_s         = 4'b1111;
            misaligned_s = |address[1:0];
         end
         default: begin
            be_s = 4'b0000;
         end
      endcase
      // Stores take priority when both strobes are high.
      if (MemWrite) begin
         legal_s = (fun3 == 3'b000) || (fun3 == 3'b001) || (fun3 == 3'b010);
      end else begin
         legal_s = (fun3 == 3'b000) || (fun3 == 3'b001) || (fun3 == 3'b010) ||
                   (fun3 == 3'b100) || (fun3 == 3'b101);
      end
   end

   // IDLE term is combinational so the PC freezes in the same cycle the access appears.
   assign stall = (state_r == REQ) || ((state_r == IDLE) && access_s && !reset);

   // Access sequencer with registered bus and result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         lo_r        <= 2'b00;
         f3_r        <= 3'b000;
         mem_data_r  <= 32'h0000_0000;
         fault_r     <= 1'b0;
         bus_req_r   <= 1'b0;
         bus_we_r    <= 1'b0;
         bus_addr_r  <= 32'h0000_0000;
         bus_wdata_r <= 32'h0000_0000;
         bus_be_r    <= 4'b0000;
      end else begin
         case (state_r)
            IDLE: begin
               fault_r <= 1'b0;
               if (access_s && legal_s && !misaligned_s) begin
                  lo_r        <= address[1:0];
                  f3_r        <= fun3;
                  bus_we_r    <= MemWrite;
                  bus_addr_r  <= {address[31:2], 2'b00};
                  bus_wdata_r <= wdata_s;
                  bus_be_r    <= be_s;
                  bus_req_r   <= 1'b1;
                  cnt_r       <= '0;
                  state_r     <= REQ;
               end else if (access_s) begin
                  fault_r <= 1'b1;
                  state_r <= ERR;
               end else begin
                  state_r <= IDLE;
               end
            end
            REQ: begin
               if (bus_ready) begin
                  bus_req_r <= 1'b0;
                  if (!bus_we_r) begin
                     mem_data_r <= extend_load(bus_rdata, lo_r, f3_r);
                  end else begin
                     mem_data_r <= mem_data_r;
                  end
                  state_r <= DONE;
               end else if (cnt_r == CNT_LAST) begin
                  bus_req_r <= 1'b0;
                  fault_r   <= 1'b1;
                  state_r   <= ERR;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            ERR: begin
               fault_r <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               bus_req_r <= 1'b0;
               fault_r   <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   assign MemData_out = mem_data_r;
   assign fault       = fault_r;
   assign bus_req     = bus_req_r;
   assign bus_we      = bus_we_r;
   assign bus_addr    = bus_addr_r;
   assign bus_wdata   = bus_wdata_r;
   assign bus_be      = bus_be_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: stores, loads, faults, timeout and mid-access reset.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  fun3;
   logic [31:0] address;
   logic [31:0] Write_data;
   logic [31:0] MemData_out;
   logic        stall;
   logic        fault;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   int total = 0;
   int bad   = 0;

   load_store_unit #(.TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .fun3(fun3),
      .address(address), .Write_data(Write_data), .MemData_out(MemData_out), .stall(stall),
      .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; fun3 = 3'b000;
      address = 32'h0; Write_data = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
      repeat (2) @(negedge clk);
      total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", bus_req); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", stall); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b want=0", fault); end
      total++; if (MemData_out !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", MemData_out); end
      total++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== 69'h0) begin bad++; $display("FAIL rst_bus got=%b/%h/%h/%h want=0", bus_we, bus_be, bus_addr, bus_wdata); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_sw();
      MemWrite = 1'b1; fun3 = 3'b010; address = 32'h100; Write_data = 32'hDEADBEEF; bus_ready = 1'b1;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL sw_stall_idle got=%b want=1", stall); end
      @(negedge clk);
      total++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL sw_req got=%b%b%b want=111", bus_req, bus_we, stall); end
      total++; if (bus_addr !== 32'h100) begin bad++; $display("FAIL sw_addr got=%h want=00000100", bus_addr); end
      total++; if (bus_be !== 4'hF) begin bad++; $display("FAIL sw_be got=%h want=f", bus_be); end
      total++; if (bus_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%h want=deadbeef", bus_wdata); end
      @(negedge clk);
      total++; if (stall !== 1'b0 || bus_req !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL sw_done got=%b%b%b want=000", stall, bus_req, fault); end
      total++; if (MemData_out !== 32'h0) begin bad++; $display("FAIL sw_keepdata got=%h want=0", MemData_out); end
      MemWrite = 1'b0; bus_ready = 1'b0;
      @(negedge clk);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL sw_idle_stall got=%b want=0", stall); end
   endtask

   task automatic test_sb_wait();
      MemWrite = 1'b1; fun3 = 3'b000; address = 32'h103; Write_data = 32'h000000A5; bus_ready = 1'b0;
      @(negedge clk);
      total++; if (bus_addr !== 32'h100) begin bad++; $display("FAIL sb_addr got=%h want=00000100", bus_addr); end
      total++; if (bus_be !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b want=1000", bus_be); end
      total++; if (bus_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata got=%h want=a5a5a5a5", bus_wdata); end
      @(negedge clk);
      total++; if (bus_req !== 1'b1 || stall !== 1'b1 || bus_be !== 4'b1000) begin bad++; $display("FAIL sb_wait got=%b%b be=%b want=11 be=1000", bus_req, stall, bus_be); end
      bus_ready = 1'b1;
      @(negedge clk);
      total++; if (bus_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL sb_done got=%b%b want=00", bus_req, stall); end
      MemWrite = 1'b0; bus_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_loads();
      logic [2:0]  f3v [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b000, 3'b010};
      logic [31:0] adv [7] = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101, 32'h104};
      logic [31:0] rdv [7] = '{32'h12F03456, 32'h12F03456, 32'h12F03456, 32'h12F03456,
                               32'h00008001, 32'h12F03456, 32'h12F03456};
      logic [3:0]  bev [7] = '{4'b0100, 4'b0100, 4'b1100, 4'b0011, 4'b0011, 4'b0010, 4'b1111};
      logic [31:0] exv [7] = '{32'hFFFFFFF0, 32'h000000F0, 32'h000012F0, 32'h00003456,
                               32'hFFFF8001, 32'h00000034, 32'h12F03456};
      for (int i = 0; i < 7; i++) begin
         MemRead = 1'b1; fun3 = f3v[i]; address = adv[i]; bus_rdata = rdv[i]; bus_ready = 1'b1;
         @(negedge clk);
         total++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_be !== bev[i] || bus_addr !== (adv[i] & 32'hFFFFFFFC)) begin
            bad++; $display("FAIL load%0d_bus got=%b%b be=%b addr=%h want=10 be=%b", i, bus_req, bus_we, bus_be, bus_addr, bev[i]); end
         @(negedge clk);
         total++; if (MemData_out !== exv[i]) begin bad++; $display("FAIL load%0d_data got=%h want=%h", i, MemData_out, exv[i]); end
         MemRead = 1'b0; bus_ready = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_sh_keeps_data();
      MemWrite = 1'b1; fun3 = 3'b001; address = 32'h102; Write_data = 32'h1234BEEF; bus_ready = 1'b1;
      @(negedge clk);
      total++; if (bus_wdata !== 32'hBEEFBEEF || bus_be !== 4'b1100) begin bad++; $display("FAIL sh_lanes got=%h be=%b want=beefbeef be=1100", bus_wdata, bus_be); end
      @(negedge clk);
      total++; if (MemData_out !== 32'h12F03456) begin bad++; $display("FAIL sh_keepdata got=%h want=12f03456", MemData_out); end
      MemWrite = 1'b0; bus_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_faults();
      logic        wrv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [2:0]  f3v [4] = '{3'b010, 3'b011, 3'b001, 3'b100};
      logic [31:0] adv [4] = '{32'h102, 32'h100, 32'h101, 32'h100};
      for (int i = 0; i < 4; i++) begin
         MemRead = ~wrv[i]; MemWrite = wrv[i]; fun3 = f3v[i]; address = adv[i]; bus_ready = 1'b1;
         #1;
         total++; if (stall !== 1'b1) begin bad++; $display("FAIL fault%0d_stall got=%b want=1", i, stall); end
         @(negedge clk);
         total++; if (fault !== 1'b1 || bus_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL fault%0d_err got=%b%b%b want=100", i, fault, bus_req, stall); end
         total++; if (MemData_out !== 32'h12F03456) begin bad++; $display("FAIL fault%0d_data got=%h want=12f03456", i, MemData_out); end
         MemRead = 1'b0; MemWrite = 1'b0; bus_ready = 1'b0;
         @(negedge clk);
         total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault%0d_pulse got=%b want=0", i, fault); end
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      int stall_low = 0;
      MemRead = 1'b1; fun3 = 3'b010; address = 32'h200; bus_ready = 1'b0;
      @(negedge clk);
      while (bus_req === 1'b1 && n < 100) begin
         n++;
         if (stall !== 1'b1) stall_low++;
         @(negedge clk);
      end
      total++; if (n !== 64) begin bad++; $display("FAIL to_req_cycles got=%0d want=64", n); end
      total++; if (stall_low !== 0) begin bad++; $display("FAIL to_stall_low got=%0d want=0", stall_low); end
      total++; if (fault !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL to_err got=%b%b want=10", fault, stall); end
      total++; if (MemData_out !== 32'h12F03456) begin bad++; $display("FAIL to_data got=%h want=12f03456", MemData_out); end
      MemRead = 1'b0;
      @(negedge clk);
      total++; if (fault !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL to_after got=%b%b want=00", fault, bus_req); end
   endtask

   task automatic test_back_to_back();
      MemWrite = 1'b1; fun3 = 3'b010; address = 32'h10; Write_data = 32'h11223344; bus_ready = 1'b1;
      repeat (2) @(negedge clk);
      MemWrite = 1'b0; MemRead = 1'b1; fun3 = 3'b100; address = 32'h13; bus_rdata = 32'h11223344;
      @(negedge clk);
      total++; if (stall !== 1'b1 || bus_req !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b%b want=10", stall, bus_req); end
      @(negedge clk);
      total++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_be !== 4'b1000) begin bad++; $display("FAIL b2b_req got=%b%b be=%b want=10 be=1000", bus_req, bus_we, bus_be); end
      @(negedge clk);
      total++; if (MemData_out !== 32'h00000011) begin bad++; $display("FAIL b2b_data got=%h want=00000011", MemData_out); end
      MemRead = 1'b0; bus_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      MemRead = 1'b1; fun3 = 3'b010; address = 32'h100; bus_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rmid_inreq got=%b want=1", bus_req); end
      reset = 1'b1;
      @(negedge clk);
      total++; if (bus_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rmid_drop got=%b%b want=00", bus_req, stall); end
      total++; if (MemData_out !== 32'h0) begin bad++; $display("FAIL rmid_data got=%h want=0", MemData_out); end
      reset = 1'b0; MemRead = 1'b0;
      @(negedge clk);
      total++; if (bus_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rmid_noretry got=%b%b want=00", bus_req, stall); end
   endtask

   initial begin
      test_reset();
      test_sw();
      test_sb_wait();
      test_loads();
      test_sh_keeps_data();
      test_faults();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
